bof_log_reader: RTL and testbench
=================================

Name: bof_log_reader

Overview:
- Drain side of the heap-overflow range log. The overflow detector pushes one record per closed overflow range: start, end, store PC and a crash flag.
- This block queues records in a small FIFO and serialises each one as 32-bit words over a valid/ready stream to the debug/crash-report path (UART dumper or CSR window).
- It sits beside the detector in the execute stage, clocked in the core domain.

Parameters:
- DEPTH, 4, number of record slots; power of two, minimum 2.
- SEQ_W, 8, width of the per-record sequence number.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; synchronous, active-low
- wr_en_i  in  1  one-cycle push pulse from the detector
- wr_start_i  in  32  first byte address of the overflow range
- wr_end_i  in  32  last byte address of the overflow range
- wr_pc_i  in  32  PC of the store that closed the range
- wr_crash_i  in  1  record caused a crash request
- flush_i  in  1  discard all queued records and abort the current record
- rd_valid_o  out  1  stream word valid
- rd_data_o  out  32  stream word
- rd_last_o  out  1  final word of the current record
- rd_ready_i  in  1  consumer accepts the word
- count_o  out  $clog2(DEPTH)+1  records queued, including the one being sent
- empty_o  out  1  count_o == 0
- overflow_o  out  1  sticky: at least one push dropped; cleared only by reset
- drop_cnt_o  out  8  dropped pushes, saturating at 255

Behaviour:
- Reset (rst_ni low at a clock edge): all outputs 0 except empty_o = 1; FIFO pointers 0; sequence counter 0; FSM in IDLE. Reset mid-record aborts it with no further words.
- Push: accepted if FIFO not full, or if the head record's final word handshakes in the same cycle (full plus simultaneous pop is accepted).
  - Accepted push stores {start, end, pc, crash, seq}, then increments seq modulo 2^SEQ_W.
  - Rejected push sets overflow_o and increments drop_cnt_o (saturating). seq does not increment.
- FSM states: IDLE -> HDR -> START -> END -> IDLE.
  - IDLE: if FIFO not empty, load HDR word and raise rd_valid_o on the next edge.
  - Minimum latency: a push in cycle N gives rd_valid_o = 1 in cycle N+1 when the FSM was idle with an empty FIFO.
  - Each state advances only on rd_valid_o && rd_ready_i.
  - On the last word's handshake: pop the head. If the FIFO is still non-empty, go directly to HDR with valid held high (back-to-back, no bubble). Otherwise go to IDLE with valid low.
  - While rd_valid_o && !rd_ready_i, rd_data_o and rd_last_o must hold stable.
- Word formats:
  - HDR: [31:24] = 8'hB0; [23:16] = seq (zero-extended if SEQ_W < 8); [15] = crash; [14:0] = length.
  - length = wr_end - wr_start + 1, computed in 33 bits, saturating at 15'h7FFF. If end < start, length = 0.
  - START: wr_start. END: wr_end, with rd_last_o = 1.
- flush_i has priority over everything in that cycle.
  - Next cycle: FIFO empty, count_o = 0, FSM in IDLE, rd_valid_o = 0.
  - A push in the same cycle is discarded and not counted as a drop.
  - seq, overflow_o and drop_cnt_o are not affected.
- count_o updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- Pointer wrap at DEPTH is natural (power-of-two pointers plus an extra wrap bit).

Optional Feature:
- Macro: BOF_LOG_PC_EN.
- Defined: each record is 4 words, HDR, START, END, PC. rd_last_o is asserted on the PC word only, and HDR bit [14] = 1 to flag the extended format.
- Undefined: the PC is not stored (no storage inferred), records are 3 words, and HDR bit [14] = 0.

Test Plan:
- Basic record: push start=0x80001000, end=0x80001027, crash=0, rd_ready_i held 1 -> valid from the next cycle; words 0xB0000028, 0x80001000, 0x80001027 on consecutive cycles; rd_last_o on the third word only.
- Backpressure: same push, rd_ready_i = 0 for 5 cycles on the START word -> rd_data_o stays 0x80001000 and valid stays high; stream resumes with no lost or duplicated word.
- Full/drop: DEPTH=4, 6 pushes with rd_ready_i = 0 -> count_o = 4, overflow_o = 1, drop_cnt_o = 2. Draining yields seq 0..3. The next accepted push carries seq 4.
- Full plus pop: FIFO full, push in the same cycle as the END handshake -> push accepted, count_o stays 4, drop_cnt_o unchanged.
- Flush mid-record: flush_i asserted during START with a simultaneous push -> next cycle rd_valid_o = 0, count_o = 0, drop_cnt_o unchanged. A later push yields HDR with seq continuing from before the flush.
- Edge fields:
  - end < start -> HDR length 0.
  - start=0x80000000, end=0x8000FFFF -> length 0x7FFF.
  - crash=1 -> HDR bit 15 set.
  - With BOF_LOG_PC_EN: 4 words, last = PC, bit 14 = 1.

Source files
------------

// File: rtl/bof_log_reader.sv
// Heap-overflow range log drain: queues detector records and streams each one as HDR/START/END words.
// Define BOF_LOG_PC_EN to store the closing store PC and append it as a fourth word.
module bof_log_reader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [31:0]              wr_start_i,
  input  logic [31:0]              wr_end_i,
  input  logic [31:0]              wr_pc_i,
  input  logic                     wr_crash_i,
  input  logic                     flush_i,
  output logic                     rd_valid_o,
  output logic [31:0]              rd_data_o,
  output logic                     rd_last_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_START = 3'd2,
    S_END   = 3'd3,
    S_PC    = 3'd4
  } state_e;

`ifdef BOF_LOG_PC_EN
  localparam state_e LAST_ST = S_PC;
  localparam logic   PC_FLAG = 1'b1;
`else
  localparam state_e LAST_ST = S_END;
  localparam logic   PC_FLAG = 1'b0;
`endif

  // Inclusive byte length of a range, saturated to the 15-bit header field.
  function automatic logic [14:0] range_len(input logic [31:0] s, input logic [31:0] e);
    logic [32:0] diff;
    diff = {1'b0, e} - {1'b0, s} + 33'd1;
    if (e < s) begin
      range_len = 15'd0;
    end else if (diff > 33'h0_0000_7FFF) begin
      range_len = 15'h7FFF;
    end else begin
      range_len = diff[14:0];
    end
  endfunction

  function automatic logic [31:0] hdr_word(input logic [SEQ_W-1:0] seq,
                                           input logic crash,
                                           input logic [14:0] len);
    logic [7:0] seq8;
    seq8     = 8'(seq);
    hdr_word = {8'hB0, seq8, crash, len | {PC_FLAG, 14'd0}};
  endfunction

  // Record storage
  logic [31:0]      start_q   [DEPTH];
  logic [31:0]      start_d   [DEPTH];
  logic [31:0]      end_q     [DEPTH];
  logic [31:0]      end_d     [DEPTH];
  logic             crash_q   [DEPTH];
  logic             crash_d   [DEPTH];
  logic [SEQ_W-1:0] rec_seq_q [DEPTH];
  logic [SEQ_W-1:0] rec_seq_d [DEPTH];
`ifdef BOF_LOG_PC_EN
  logic [31:0]      pc_q      [DEPTH];
  logic [31:0]      pc_d      [DEPTH];
`else
  logic             unused_pc_s;
  assign unused_pc_s = ^wr_pc_i;
`endif

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             empty_q, empty_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_last_q, rd_last_d;

  logic [PTR_W-1:0] rd_idx_s, wr_idx_s, nxt_idx_s, src_idx_s;
  logic             full_s, hs_s, pop_s, push_ok_s, drop_s, more_s, load_s, src_bypass_s;
  logic [31:0]      src_start_s, src_end_s;
  logic             src_crash_s;
  logic [SEQ_W-1:0] src_seq_s;

  assign rd_idx_s  = rd_ptr_q[PTR_W-1:0];
  assign wr_idx_s  = wr_ptr_q[PTR_W-1:0];
  assign nxt_idx_s = rd_idx_s + PTR_W'(1);

  // Handshake, push acceptance and drop classification
  always_comb begin
    full_s    = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) && (rd_idx_s == wr_idx_s);
    hs_s      = rd_valid_q && rd_ready_i;
    pop_s     = hs_s && rd_last_q && !flush_i;
    push_ok_s = wr_en_i && !flush_i && (!full_s || pop_s);
    drop_s    = wr_en_i && !flush_i && full_s && !pop_s;
    more_s    = (count_q > CNT_W'(1)) || push_ok_s;
  end

  // Pointers, occupancy, sequence number and drop statistics
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    seq_d      = seq_q;
    overflow_d = overflow_q | drop_s;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + CNT_W'(1);
        seq_d    = seq_q + SEQ_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (count_d == CNT_W'(0));
  end

  // Record storage write port
  always_comb begin
    start_d   = start_q;
    end_d     = end_q;
    crash_d   = crash_q;
    rec_seq_d = rec_seq_q;
`ifdef BOF_LOG_PC_EN
    pc_d      = pc_q;
`endif
    if (push_ok_s) begin
      start_d[wr_idx_s]   = wr_start_i;
      end_d[wr_idx_s]     = wr_end_i;
      crash_d[wr_idx_s]   = wr_crash_i;
      rec_seq_d[wr_idx_s] = seq_q;
`ifdef BOF_LOG_PC_EN
      pc_d[wr_idx_s]      = wr_pc_i;
`endif
    end else begin
      start_d = start_q;
    end
  end

  // Record storage registers; contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    start_q   <= start_d;
    end_q     <= end_d;
    crash_q   <= crash_d;
    rec_seq_q <= rec_seq_d;
`ifdef BOF_LOG_PC_EN
    pc_q      <= pc_d;
`endif
  end

  // Control and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Next-state: walk the words of a record, chaining records without a bubble
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((count_q != CNT_W'(0)) || push_ok_s) begin
            state_d = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HDR: begin
          if (hs_s) begin
            state_d = S_START;
          end else begin
            state_d = S_HDR;
          end
        end
        S_START: begin
          if (hs_s) begin
            state_d = S_END;
          end else begin
            state_d = S_START;
          end
        end
        S_END: begin
          if (hs_s && (LAST_ST == S_PC)) begin
            state_d = S_PC;
          end else if (hs_s) begin
            state_d = more_s ? S_HDR : S_IDLE;
          end else begin
            state_d = S_END;
          end
        end
        S_PC: begin
          if (hs_s) begin
            state_d = more_s ? S_HDR : S_IDLE;
          end else begin
            state_d = S_PC;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output: pick the record feeding the next header (stored or arriving this cycle) and load the next word
  always_comb begin
    if (state_q == S_IDLE) begin
      src_idx_s    = rd_idx_s;
      src_bypass_s = (count_q == CNT_W'(0));
    end else begin
      src_idx_s    = nxt_idx_s;
      src_bypass_s = (count_q == CNT_W'(1));
    end
    src_start_s = src_bypass_s ? wr_start_i : start_q[src_idx_s];
    src_end_s   = src_bypass_s ? wr_end_i   : end_q[src_idx_s];
    src_crash_s = src_bypass_s ? wr_crash_i : crash_q[src_idx_s];
    src_seq_s   = src_bypass_s ? seq_q      : rec_seq_q[src_idx_s];
    load_s      = !flush_i && (hs_s || ((state_q == S_IDLE) && (state_d == S_HDR)));

    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    if (flush_i) begin
      rd_valid_d = 1'b0;
      rd_data_d  = 32'd0;
      rd_last_d  = 1'b0;
    end else if (load_s) begin
      rd_valid_d = (state_d != S_IDLE);
      rd_last_d  = (state_d == LAST_ST);
      case (state_d)
        S_HDR:   rd_data_d = hdr_word(src_seq_s, src_crash_s, range_len(src_start_s, src_end_s));
        S_START: rd_data_d = start_q[rd_idx_s];
        S_END:   rd_data_d = end_q[rd_idx_s];
`ifdef BOF_LOG_PC_EN
        S_PC:    rd_data_d = pc_q[rd_idx_s];
`endif
        default: rd_data_d = 32'd0;
      endcase
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bof_log_reader.sv
// Scoreboard bench for bof_log_reader: a record-level model predicts the word stream and queue state.
module tb_bof_log_reader;

  localparam int DEPTH = 4;
`ifdef BOF_LOG_PC_EN
  localparam int NW = 4;
  localparam bit PCX = 1'b1;
`else
  localparam int NW = 3;
  localparam bit PCX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_start_i = 32'd0;
  logic [31:0] wr_end_i = 32'd0;
  logic [31:0] wr_pc_i = 32'd0;
  logic        wr_crash_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        rd_ready_i = 1'b0;
  logic [2:0]  count_o;
  logic        empty_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;

  bof_log_reader #(.DEPTH(DEPTH), .SEQ_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_start_i(wr_start_i),
    .wr_end_i(wr_end_i), .wr_pc_i(wr_pc_i), .wr_crash_i(wr_crash_i), .flush_i(flush_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .rd_ready_i(rd_ready_i), .count_o(count_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: record count, words already sent from the head, and statistics
  logic [32:0] exp_q[$];
  int m_cnt = 0, m_k = 0, m_seq = 0, m_drops = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] model_hdr(int seq, bit crash, logic [31:0] s, logic [31:0] e);
    longint len;
    if (e < s) len = 0;
    else len = longint'(e) - longint'(s) + 1;
    if (len > 32767) len = 32767;
    if (PCX) len = len | 16384;
    return 32'hB000_0000 + 32'((seq % 256) * 65536) + (crash ? 32'h8000 : 32'h0) + 32'(len);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_k = 0; m_seq = 0; m_drops = 0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // One clock: check registered state against the model, apply inputs, advance the model
  task automatic step(input bit we, input logic [31:0] s, input logic [31:0] e,
                      input logic [31:0] pc, input bit cr, input bit rdy, input bit fl);
    bit hs, lastw, ok;
    @(negedge clk);
    chk("count", count_o, m_cnt);
    chk("empty", empty_o, m_cnt == 0);
    chk("valid", rd_valid_o, m_cnt > 0);
    chk("overflow", overflow_o, m_ovf);
    chk("drop_cnt", drop_cnt_o, m_drops);
    wr_en_i = we; wr_start_i = s; wr_end_i = e; wr_pc_i = pc; wr_crash_i = cr;
    rd_ready_i = rdy; flush_i = fl;
    if (fl) begin
      m_cnt = 0; m_k = 0;
      exp_q.delete();
    end else begin
      hs = (m_cnt > 0) && rdy;
      lastw = hs && (m_k == NW - 1);
      ok = we && ((m_cnt < DEPTH) || lastw);
      if (lastw) begin m_cnt--; m_k = 0; end
      else if (hs) m_k++;
      if (ok) begin
        m_cnt++;
        exp_q.push_back({1'b0, model_hdr(m_seq, cr, s, e)});
        exp_q.push_back({1'b0, s});
        exp_q.push_back({!PCX, e});
        if (PCX) exp_q.push_back({1'b1, pc});
        m_seq = (m_seq + 1) % 256;
      end else if (we) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] e, input bit cr, input bit rdy);
    step(1'b1, s, e, $urandom, cr, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; wr_en_i = 1'b0; flush_i = 1'b0; rd_ready_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Monitor: every accepted word is popped from the scoreboard; stalled words must hold
  bit stall_pend = 1'b0;
  logic [32:0] stall_word;
  initial begin
    logic [32:0] w;
    forever begin
      @(negedge clk);
      #1;
      if (stall_pend) begin
        chk("stall_hold", {rd_valid_o, rd_last_o, rd_data_o}, {1'b1, stall_word});
      end
      if (rst_ni && !flush_i && rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %0h, expected no word", rd_data_o);
        end else begin
          w = exp_q.pop_front();
          chk("word", {rd_last_o, rd_data_o}, w);
        end
      end
      stall_pend = rst_ni && !flush_i && rd_valid_o && !rd_ready_i;
      stall_word = {rd_last_o, rd_data_o};
    end
  end

  initial begin
    bit done;
    logic [31:0] s, e;
    do_reset();
    idle(2, 1'b1);

    // Basic record, then backpressure on START
    push(32'h8000_1000, 32'h8000_1027, 1'b0, 1'b1);
    idle(5, 1'b1);
    push(32'h8000_1000, 32'h8000_1027, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Fill past capacity with the consumer stalled, drain, then one more
    for (int i = 0; i < 6; i++) push(32'h9000_0000 + 32'(i * 16), 32'h9000_000F + 32'(i * 16), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4 * NW + 4, 1'b1);
    push(32'hA000_0000, 32'hA000_0003, 1'b1, 1'b1);
    idle(NW + 2, 1'b1);

    // Full FIFO with a push landing on the head's last-word handshake
    for (int i = 0; i < 4; i++) push(32'hB000_0000 + 32'(i * 256), 32'hB000_00FF + 32'(i * 256), 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 3 * NW; i++) begin
      if (!done && m_cnt == DEPTH && m_k == NW - 1) begin
        push(32'hC000_0000, 32'hC000_0010, 1'b1, 1'b1);
        done = 1'b1;
      end else begin
        idle(1, 1'b1);
      end
    end
    idle(5 * NW + 4, 1'b1);

    // Flush during START together with a push
    push(32'hD000_0000, 32'hD000_0100, 1'b0, 1'b1);
    push(32'hD000_1000, 32'hD000_1100, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD_0000, 32'hDEAD_0010, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    push(32'hE000_0000, 32'hE000_0007, 1'b0, 1'b1);
    idle(NW + 2, 1'b1);

    // Edge fields: inverted range, saturated length, crash bit
    push(32'h8000_0100, 32'h8000_00FF, 1'b0, 1'b1);
    idle(NW + 1, 1'b1);
    push(32'h8000_0000, 32'h8000_FFFF, 1'b0, 1'b1);
    idle(NW + 1, 1'b1);
    push(32'h8000_0000, 32'h8000_3FFF, 1'b1, 1'b1);
    idle(NW + 1, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      s = $urandom;
      case ($urandom_range(0, 3))
        0: e = s + 32'($urandom_range(0, 300));
        1: e = s - 32'($urandom_range(1, 300));
        2: e = s + 32'($urandom_range(32760, 70000));
        default: e = $urandom;
      endcase
      step($urandom_range(0, 99) < 35, s, e, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
    end
    idle(5 * NW + 4, 1'b1);

    // Reset in the middle of a record
    push(32'hF000_0000, 32'hF000_0040, 1'b0, 1'b1);
    idle(1, 1'b1);
    do_reset();
    idle(3, 1'b1);
    push(32'hF100_0000, 32'hF100_0004, 1'b0, 1'b1);
    idle(NW + 4, 1'b1);

    @(negedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
